mem_stage_lsu: RTL and testbench
================================

# mem_stage_lsu

Memory-stage load/store unit that consumes the EX/MEM pipeline outputs: the address, the store data and the decoded control. It turns each live memory instruction into one request/response transaction on the data-memory bus, with byte-lane steering and load extension. While a transaction is outstanding it stalls the pipeline. The loaded word goes to the MEM/WB path, and misalignment and bus errors are flagged to the trap logic.

## Interface
Reset is fixed for this block: one clock; reset is asynchronous and active-low.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles to wait for a response before a bus error is forced (range 1..65535).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- valid_m  in  1  the EX/MEM slot holds a live instruction
- DataMemoryAddress_m  in  32  byte address
- WD_m  in  32  store data
- ctrl_m  in  bundle_decode_t  fields used: MemW, MemR, MemSize (mem_size_t), MemUnsigned
- stall_m  out  1  holds EX/MEM and all upstream stages
- misalign_m  out  1  access not naturally aligned
- bus_err_m  out  1  error response or timeout
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  request accepted
- mem_req_addr  out  32  word address (bits [1:0] = 0)
- mem_req_we  out  1  1 = write
- mem_req_wstrb  out  4  byte enables
- mem_req_wdata  out  32  lane-replicated write data
- mem_rsp_valid  in  1  response valid (read data or write acknowledge)
- mem_rsp_rdata  in  32  read word
- mem_rsp_err  in  1  response carries an error
- ReadData_w  out  32  extended load result
- load_valid_w  out  1  ReadData_w valid this cycle

## Operation
- access_m = valid_m & (MemR | MemW) & ~misalign_m.
- Misalignment rules, by address offset off = DataMemoryAddress_m[1:0]:
  - HALF is misaligned when off[0] = 1.
  - WORD is misaligned when off != 0.
  - misalign_m is combinational, asserted only in IDLE, and never issues a request or a stall.
- Simultaneous MemR and MemW is treated as a write.
- FSM states: IDLE, REQ, RSP, DONE.
  - IDLE: on access_m, latch the word address, we, wstrb, wdata, size, unsigned flag and off; go to REQ.
  - REQ: mem_req_valid = 1 with the latched fields held stable. On mem_req_ready go to RSP and clear the timeout counter.
  - RSP: the counter increments each cycle. On mem_rsp_valid, capture the extended rdata (loads only), capture the err flag, and go to DONE. If the counter reaches TIMEOUT_CYCLES with no response, set err and go to DONE.
  - DONE: one cycle, then IDLE.
- stall_m = access_m & (state != DONE). It is combinational and is therefore high in the IDLE cycle that detects the access.
- Write steering:
  - BYTE: wstrb = 4'b0001 << off; wdata = {4{WD_m[7:0]}}.
  - HALF: wstrb = 4'b0011 << off; wdata = {2{WD_m[15:0]}}.
  - WORD: wstrb = 4'hF; wdata = WD_m.
- Load extraction: shift rdata right by 8*off, take 8 or 16 or 32 bits, then sign-extend or zero-extend according to MemUnsigned.
- load_valid_w is high in DONE for loads with no error. bus_err_m is high in DONE when err is set.
- A response arriving in IDLE or REQ is ignored.

## Timing
- Reset values: state IDLE, mem_req_valid 0, mem_req_addr/wstrb/wdata 0, mem_req_we 0, ReadData_w 0, load_valid_w 0, bus_err_m 0, counter 0.
- Minimum access: 4 cycles (IDLE, REQ, RSP, DONE), with a zero-wait accept and a response in the first RSP cycle. stall_m is high for the first 3 of these cycles.
- Each extra cycle of mem_req_ready low or of response delay adds one stall cycle.
- The request fields must not change while mem_req_valid = 1 and mem_req_ready = 0.
- Back-to-back: the next instruction is in EX/MEM the cycle after DONE, and the FSM detects it in IDLE that cycle.
- Reset asserted mid-transaction: return to IDLE immediately and drop the outstanding transaction. Any late response is then ignored.
- Timeout: bus_err_m is asserted TIMEOUT_CYCLES+1 cycles after the RSP entry edge.

## Structure
- Pkg additions:
  - mem_size_t enum {BYTE, HALF, WORD}.
  - MemR, MemSize and MemUnsigned fields in bundle_decode_t.
  - lsu_state_t enum.
- Sub-module load_extract: combinational; takes rdata, off, size and unsigned, returns the 32-bit result.

## Test plan
- SB with addr 0x1003 and WD 0xAABBCCDD, ready and response immediate: wstrb 1000, wdata 0xDDDDDDDD, mem_req_addr 0x1000, stall_m high for 3 cycles.
- LB then LBU at addr 0x2001 with rdata 0x0000F100: ReadData_w 0xFFFFFFF1, then 0x000000F1, with load_valid_w pulsing one cycle each.
- LH at addr 0x2001: misalign_m = 1, no mem_req_valid, stall_m = 0.
- LW with mem_req_ready held low 5 cycles and response 3 cycles later: request fields stable throughout, stall_m high for 11 cycles, correct data.
- TIMEOUT_CYCLES = 4 with no response: bus_err_m pulses in DONE and load_valid_w stays 0.
- Reset asserted while in RSP, then a response arrives: outputs at reset values, the response is ignored, and the next access completes normally.

Source files
------------

// File: rtl/mem_stage_lsu_pkg.sv
// Shared types for the memory-stage load/store unit: access sizes, the
// decoded-control bundle and the transaction FSM states.
package mem_stage_lsu_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_size_t;

  typedef struct packed {
    logic      MemW;
    logic      MemR;
    mem_size_t MemSize;
    logic      MemUnsigned;
  } bundle_decode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  // Natural alignment: halves on even bytes, words on 4-byte boundaries.
  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] off);
    case (size)
      HALF:    return off[0];
      WORD:    return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_lsu_load_extract.sv
// Picks the addressed byte/half/word out of a read word and extends it
// to 32 bits.
module load_extract
  import mem_stage_lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_off,
  input  mem_size_t   i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_result
);

  logic [31:0] w_shifted;

  assign w_shifted = i_rdata >> {i_off, 3'b000};

  always_comb begin
    case (i_size)
      BYTE:    o_result = {{24{~i_unsigned & w_shifted[7]}}, w_shifted[7:0]};
      HALF:    o_result = {{16{~i_unsigned & w_shifted[15]}}, w_shifted[15:0]};
      default: o_result = w_shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage LSU: one request/response bus transaction per live memory
// instruction, stalling the pipeline until the response has been taken.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           valid_m,
  input  logic [31:0]    DataMemoryAddress_m,
  input  logic [31:0]    WD_m,
  input  bundle_decode_t ctrl_m,
  output logic           stall_m,
  output logic           misalign_m,
  output logic           bus_err_m,
  output logic           mem_req_valid,
  input  logic           mem_req_ready,
  output logic [31:0]    mem_req_addr,
  output logic           mem_req_we,
  output logic [3:0]     mem_req_wstrb,
  output logic [31:0]    mem_req_wdata,
  input  logic           mem_rsp_valid,
  input  logic [31:0]    mem_rsp_rdata,
  input  logic           mem_rsp_err,
  output logic [31:0]    ReadData_w,
  output logic           load_valid_w
);

  localparam logic [15:0] TimeoutLimit = 16'(TIMEOUT_CYCLES);

  lsu_state_t  r_state;
  logic [15:0] r_cnt;
  mem_size_t   r_size;
  logic        r_unsigned;
  logic [1:0]  r_off;

  logic [1:0]  w_off;
  logic        w_memOp;
  logic        w_access;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  logic [31:0] w_loadResult;

  assign w_off      = DataMemoryAddress_m[1:0];
  assign w_memOp    = valid_m & (ctrl_m.MemR | ctrl_m.MemW);
  assign misalign_m = (r_state == IDLE) & w_memOp & is_misaligned(ctrl_m.MemSize, w_off);
  assign w_access   = w_memOp & ~misalign_m;
  // Drops in DONE so EX/MEM can advance on the edge that returns us to IDLE.
  assign stall_m    = w_access & (r_state != DONE);

  always_comb begin
    w_wstrb = 4'hF;
    w_wdata = WD_m;
    case (ctrl_m.MemSize)
      BYTE: begin
        w_wstrb = 4'b0001 << w_off;
        w_wdata = {4{WD_m[7:0]}};
      end
      HALF: begin
        w_wstrb = 4'b0011 << w_off;
        w_wdata = {2{WD_m[15:0]}};
      end
      default: ;
    endcase
  end

  load_extract u_load_extract (
    .i_rdata    (mem_rsp_rdata),
    .i_off      (r_off),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .o_result   (w_loadResult)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_size        <= BYTE;
      r_unsigned    <= 1'b0;
      r_off         <= 2'b00;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_we    <= 1'b0;
      mem_req_wstrb <= '0;
      mem_req_wdata <= '0;
      ReadData_w    <= '0;
      load_valid_w  <= 1'b0;
      bus_err_m     <= 1'b0;
    end else begin
      load_valid_w <= 1'b0;
      bus_err_m    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_access) begin
            mem_req_addr  <= {DataMemoryAddress_m[31:2], 2'b00};
            mem_req_we    <= ctrl_m.MemW;
            mem_req_wstrb <= ctrl_m.MemW ? w_wstrb : 4'h0;
            mem_req_wdata <= w_wdata;
            r_size        <= ctrl_m.MemSize;
            r_unsigned    <= ctrl_m.MemUnsigned;
            r_off         <= w_off;
            mem_req_valid <= 1'b1;
            r_state       <= REQ;
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            r_cnt         <= '0;
            r_state       <= RSP;
          end
        end
        RSP: begin
          if (mem_rsp_valid) begin
            if (!mem_req_we) ReadData_w <= w_loadResult;
            load_valid_w <= ~mem_req_we & ~mem_rsp_err;
            bus_err_m    <= mem_rsp_err;
            r_state      <= DONE;
          end else if (r_cnt == TimeoutLimit) begin
            bus_err_m <= 1'b1;
            r_state   <= DONE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: a transaction-level model predicts every
// output each cycle, plus literal checks on the headline scenarios.
module tb_mem_stage_lsu;
  import mem_stage_lsu_pkg::*;

  localparam int Timeout = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           valid_m;
  logic [31:0]    addr;
  logic [31:0]    wd;
  bundle_decode_t ctrl;
  logic           stall_m, misalign_m, bus_err_m;
  logic           mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0]    mem_req_addr, mem_req_wdata;
  logic [3:0]     mem_req_wstrb;
  logic           mem_rsp_valid, mem_rsp_err;
  logic [31:0]    mem_rsp_rdata;
  logic [31:0]    ReadData_w;
  logic           load_valid_w;

  mem_stage_lsu #(.TIMEOUT_CYCLES(Timeout)) dut (
    .clk                 (clk),
    .reset               (reset),
    .valid_m             (valid_m),
    .DataMemoryAddress_m (addr),
    .WD_m                (wd),
    .ctrl_m              (ctrl),
    .stall_m             (stall_m),
    .misalign_m          (misalign_m),
    .bus_err_m           (bus_err_m),
    .mem_req_valid       (mem_req_valid),
    .mem_req_ready       (mem_req_ready),
    .mem_req_addr        (mem_req_addr),
    .mem_req_we          (mem_req_we),
    .mem_req_wstrb       (mem_req_wstrb),
    .mem_req_wdata       (mem_req_wdata),
    .mem_rsp_valid       (mem_rsp_valid),
    .mem_rsp_rdata       (mem_rsp_rdata),
    .mem_rsp_err         (mem_rsp_err),
    .ReadData_w          (ReadData_w),
    .load_valid_w        (load_valid_w)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  bit          checkEn = 0;
  bit          expStall, expMisalign, expReqValid, expBusErr, expLoadValid, expFieldsZero;
  bit          expWe;
  logic [31:0] expAddr, expWdata, expReadData;
  logic [3:0]  expWstrb;

  int          stallCount, loadPulses, errPulses;
  logic [31:0] lastLoad, lastAddr, lastWdata;
  logic [3:0]  lastWstrb;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: expected byte lanes and replicated data for a store.
  function automatic logic [3:0] modelStrb(input mem_size_t sz, input logic [1:0] off);
    int unsigned s;
    case (sz)
      BYTE:    s = 1 << off;
      HALF:    s = 3 << off;
      default: s = 15;
    endcase
    return 4'(s);
  endfunction

  function automatic logic [31:0] modelWdata(input mem_size_t sz, input logic [31:0] d);
    case (sz)
      BYTE:    return 32'(d % 256) * 32'h01010101;
      HALF:    return 32'(d % 65536) * 32'h00010001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] modelLoad(input logic [31:0] word, input logic [1:0] off,
                                            input mem_size_t sz, input bit uns);
    int unsigned v;
    v = word / (32'd1 << (8 * off));
    case (sz)
      BYTE: begin
        v = v % 256;
        if (!uns && v >= 128) v = v + 32'hFFFFFF00;
      end
      HALF: begin
        v = v % 65536;
        if (!uns && v >= 32768) v = v + 32'hFFFF0000;
      end
      default: ;
    endcase
    return v;
  endfunction

  // Per-cycle comparison against the model, sampled away from the rising edge.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("stall_m", stall_m, expStall);
      checkOutput("misalign_m", misalign_m, expMisalign);
      checkOutput("mem_req_valid", mem_req_valid, expReqValid);
      checkOutput("bus_err_m", bus_err_m, expBusErr);
      checkOutput("load_valid_w", load_valid_w, expLoadValid);
      checkOutput("ReadData_w", ReadData_w, expReadData);
      if (expReqValid || expFieldsZero) begin
        checkOutput("mem_req_addr", mem_req_addr, expAddr);
        checkOutput("mem_req_we", mem_req_we, expWe);
        if (expWe || expFieldsZero) begin
          checkOutput("mem_req_wstrb", mem_req_wstrb, expWstrb);
          checkOutput("mem_req_wdata", mem_req_wdata, expWdata);
        end
      end
      if (stall_m) stallCount++;
      if (load_valid_w) begin
        loadPulses++;
        lastLoad = ReadData_w;
      end
      if (bus_err_m) errPulses++;
      if (mem_req_valid) begin
        lastAddr  = mem_req_addr;
        lastWstrb = mem_req_wstrb;
        lastWdata = mem_req_wdata;
      end
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic setIdleExp();
    expStall      = 0;
    expMisalign   = 0;
    expReqValid   = 0;
    expBusErr     = 0;
    expLoadValid  = 0;
    expFieldsZero = 0;
  endtask

  task automatic idleCycles(input int n);
    valid_m       = 0;
    ctrl          = '0;
    mem_req_ready = 0;
    mem_rsp_valid = 0;
    setIdleExp();
    repeat (n) nextCycle();
  endtask

  // One full access; rspDelay < 0 means the bus never answers.
  task automatic applyStimulus(input bit w, input bit r, input mem_size_t sz, input bit uns,
                               input logic [31:0] a, input logic [31:0] d, input logic [31:0] rd,
                               input bit err, input int readyDelay, input int rspDelay);
    bit tmo;
    int rspCycles;
    tmo        = rspDelay < 0;
    stallCount = 0;
    loadPulses = 0;
    errPulses  = 0;
    valid_m          = 1;
    ctrl.MemW        = w;
    ctrl.MemR        = r;
    ctrl.MemSize     = sz;
    ctrl.MemUnsigned = uns;
    addr             = a;
    wd               = d;
    mem_req_ready    = 0;
    mem_rsp_valid    = 0;
    mem_rsp_err      = 0;
    setIdleExp();
    expStall = 1;
    nextCycle();
    expReqValid = 1;
    expAddr     = {a[31:2], 2'b00};
    expWe       = w;
    expWstrb    = modelStrb(sz, a[1:0]);
    expWdata    = modelWdata(sz, d);
    for (int k = 0; k <= readyDelay; k++) begin
      mem_req_ready = (k == readyDelay);
      mem_rsp_valid = (k == 0 && readyDelay > 0);
      mem_rsp_rdata = 32'h5A5A5A5A;
      nextCycle();
    end
    mem_req_ready = 0;
    expReqValid   = 0;
    rspCycles     = tmo ? Timeout + 1 : rspDelay + 1;
    for (int j = 0; j < rspCycles; j++) begin
      mem_rsp_valid = !tmo && (j == rspDelay);
      mem_rsp_rdata = mem_rsp_valid ? rd : 32'hDEADBEEF;
      mem_rsp_err   = mem_rsp_valid ? err : 1'b0;
      nextCycle();
    end
    mem_rsp_valid = 0;
    mem_rsp_err   = 0;
    expStall      = 0;
    expBusErr     = err | tmo;
    expLoadValid  = !w && !err && !tmo;
    if (!w && !tmo) expReadData = modelLoad(rd, a[1:0], sz, uns);
    nextCycle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 0; valid_m = 0; ctrl = '0; addr = '0; wd = '0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = '0; mem_rsp_err = 0;
    setIdleExp();
    expFieldsZero = 1; expAddr = '0; expWe = 0; expWstrb = '0; expWdata = '0; expReadData = '0;
    nextCycle();
    checkEn = 1;
    nextCycle();
    nextCycle();
    reset = 1;
    idleCycles(2);

    // SB at 0x1003
    applyStimulus(1, 0, BYTE, 0, 32'h1003, 32'hAABBCCDD, 32'h0, 0, 0, 0);
    checkOutput("sb_wstrb_lit", lastWstrb, 32'h8);
    checkOutput("sb_wdata_lit", lastWdata, 32'hDDDDDDDD);
    checkOutput("sb_addr_lit", lastAddr, 32'h1000);
    checkOutput("sb_stall_lit", stallCount, 3);

    // LB then LBU back-to-back
    applyStimulus(0, 1, BYTE, 0, 32'h2001, 32'h0, 32'h0000F100, 0, 0, 0);
    checkOutput("lb_data_lit", lastLoad, 32'hFFFFFFF1);
    checkOutput("lb_pulse_lit", loadPulses, 1);
    applyStimulus(0, 1, BYTE, 1, 32'h2001, 32'h0, 32'h0000F100, 0, 0, 0);
    checkOutput("lbu_data_lit", lastLoad, 32'h000000F1);
    checkOutput("lbu_pulse_lit", loadPulses, 1);

    // Misaligned LH: no request, no stall
    valid_m = 1; ctrl.MemW = 0; ctrl.MemR = 1; ctrl.MemSize = HALF; ctrl.MemUnsigned = 0;
    addr = 32'h2001;
    setIdleExp();
    expMisalign = 1;
    nextCycle();
    nextCycle();
    idleCycles(1);

    // LW with slow accept and delayed response
    applyStimulus(0, 1, WORD, 0, 32'h2004, 32'h0, 32'hCAFEF00D, 0, 5, 3);
    checkOutput("lw_stall_lit", stallCount, 11);
    checkOutput("lw_data_lit", lastLoad, 32'hCAFEF00D);

    // Halfword stores/loads, word store, simultaneous R+W as a write
    applyStimulus(1, 0, HALF, 0, 32'h1002, 32'h1234ABCD, 32'h0, 0, 1, 1);
    checkOutput("sh_wstrb_lit", lastWstrb, 32'hC);
    checkOutput("sh_wdata_lit", lastWdata, 32'hABCDABCD);
    applyStimulus(0, 1, HALF, 0, 32'h2002, 32'h0, 32'h80017FFF, 0, 0, 0);
    checkOutput("lh_data_lit", lastLoad, 32'hFFFF8001);
    applyStimulus(0, 1, HALF, 1, 32'h2002, 32'h0, 32'h80017FFF, 0, 0, 2);
    applyStimulus(1, 0, WORD, 0, 32'h100C, 32'h01020304, 32'h0, 0, 0, 0);
    applyStimulus(1, 1, BYTE, 0, 32'h1005, 32'h000000A5, 32'h0, 0, 0, 0);
    checkOutput("rw_wstrb_lit", lastWstrb, 32'h2);
    idleCycles(1);

    // Error response and timeout
    applyStimulus(0, 1, WORD, 0, 32'h200C, 32'h0, 32'h11223344, 1, 0, 1);
    checkOutput("err_pulse_lit", errPulses, 1);
    applyStimulus(0, 1, WORD, 0, 32'h2008, 32'h0, 32'h0, 0, 0, -1);
    checkOutput("tmo_err_lit", errPulses, 1);
    checkOutput("tmo_noload_lit", loadPulses, 0);
    checkOutput("tmo_stall_lit", stallCount, 7);

    // Reset while in RSP, then a stray response
    valid_m = 1; ctrl.MemW = 0; ctrl.MemR = 1; ctrl.MemSize = WORD; ctrl.MemUnsigned = 0;
    addr = 32'h3000;
    setIdleExp();
    expStall = 1;
    nextCycle();
    expReqValid = 1; expAddr = 32'h3000; expWe = 0;
    mem_req_ready = 1;
    nextCycle();
    mem_req_ready = 0; expReqValid = 0;
    nextCycle();
    reset = 0; valid_m = 0; ctrl = '0;
    setIdleExp();
    expFieldsZero = 1; expAddr = '0; expWe = 0; expWstrb = '0; expWdata = '0; expReadData = '0;
    nextCycle();
    nextCycle();
    reset = 1;
    mem_rsp_valid = 1; mem_rsp_rdata = 32'h12345678;
    nextCycle();
    mem_rsp_valid = 0;
    nextCycle();
    applyStimulus(0, 1, BYTE, 1, 32'h3003, 32'h0, 32'h9A000000, 0, 0, 0);
    checkOutput("post_reset_lit", lastLoad, 32'h0000009A);
    idleCycles(2);

    checkEn = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
